jedro_1_lsu: RTL

JEDRO_1_LSU -- requirements
Module: jedro_1_lsu

---
 rtl/jedro_1_defines.sv | 33 +++
 rtl/jedro_1_lsu_if.sv | 25 ++
 rtl/jedro_1_lsu_ld_align.sv | 27 ++
 rtl/jedro_1_lsu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_defines.sv
// Shared LSU definitions: ctrl encodings, FSM states and request decode helpers.
package jedro_1_defines;

  typedef enum logic [3:0] {
    LSU_LB  = 4'b0000,
    LSU_LH  = 4'b0001,
    LSU_LW  = 4'b0010,
    LSU_LBU = 4'b0100,
    LSU_LHU = 4'b0101,
    LSU_SB  = 4'b1000,
    LSU_SH  = 4'b1001,
    LSU_SW  = 4'b1010
  } lsu_ctrl_e;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_e;

  localparam logic [1:0] LSU_W_BYTE = 2'b00;
  localparam logic [1:0] LSU_W_HALF = 2'b01;
  localparam logic [1:0] LSU_W_WORD = 2'b10;

  // The reserved width code 11 is handled like a word access.
  function automatic logic lsu_misaligned(input logic [3:0] ctrl, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (ctrl[1:0] == LSU_W_HALF) mis = off[0];
    else if (ctrl[1]) mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/jedro_1_lsu_if.sv
// Data-memory bus seen between the LSU (master) and a RAM (slave).
interface jedro_1_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic [DATA_WIDTH/8-1:0] dram_we;
  logic                    dram_stb;
  logic [ADDR_WIDTH-1:0]   dram_addr;
  logic [DATA_WIDTH-1:0]   dram_wdata;
  logic [DATA_WIDTH-1:0]   dram_rdata;
  logic                    dram_ack;
  logic                    dram_err;

  modport master (
    output dram_we, dram_stb, dram_addr, dram_wdata,
    input  dram_rdata, dram_ack, dram_err
  );

  modport slave (
    input  dram_we, dram_stb, dram_addr, dram_wdata,
    output dram_rdata, dram_ack, dram_err
  );

endinterface

// File: rtl/jedro_1_lsu_ld_align.sv
// Combinational load lane select and sign/zero extension; zero latency.
module jedro_1_lsu_ld_align
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            offset_i,
  input  logic [1:0]            width_i,
  input  logic                  unsigned_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];
    unique case (width_i)
      LSU_W_BYTE: data_o = {{(DATA_WIDTH-8){~unsigned_i & byte_sel[7]}}, byte_sel};
      LSU_W_HALF: data_o = {{(DATA_WIDTH-16){~unsigned_i & half_sel[15]}}, half_sel};
      default:    data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/jedro_1_lsu.sv
// Load/store unit: one outstanding bus access, request edge to stb is 1 cycle, writeback 1 cycle after ack.
// Execute stalls on busy_o; JEDRO_1_LSU_TIMEOUT_EN adds a WAIT-cycle abort counter.
module jedro_1_lsu
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    ctrl_valid_i,
  input  logic [3:0]              ctrl_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [4:0]              regdest_i,
  output logic                    busy_o,
  output logic                    rf_we_o,
  output logic [DATA_WIDTH-1:0]   rf_wdata_o,
  output logic [4:0]              regdest_o,
  output logic                    misaligned_load_o,
  output logic                    misaligned_store_o,
  output logic                    bus_err_o,
  output logic [DATA_WIDTH/8-1:0] dram_we,
  output logic                    dram_stb,
  output logic [ADDR_WIDTH-1:0]   dram_addr,
  output logic [DATA_WIDTH-1:0]   dram_wdata,
  input  logic [DATA_WIDTH-1:0]   dram_rdata,
  input  logic                    dram_ack,
  input  logic                    dram_err
);

  localparam int NB = DATA_WIDTH / 8;

  lsu_state_e            state_q, state_d;
  logic [NB-1:0]         we_q, we_d;
  logic                  stb_q, stb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic [1:0]            off_q, off_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rf_we_q, rf_we_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  mis_ld_q, mis_ld_d;
  logic                  mis_st_q, mis_st_d;
  logic                  err_q, err_d;

  logic [NB-1:0]         req_we;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  timeout;

  jedro_1_lsu_ld_align #(.DATA_WIDTH(DATA_WIDTH)) u_ld_align (
    .rdata_i    (dram_rdata),
    .offset_i   (off_q),
    .width_i    (ctrl_q[1:0]),
    .unsigned_i (ctrl_q[2]),
    .data_o     (ld_data)
  );

  // Store data is replicated so every enabled lane already carries the right byte.
  always_comb begin
    req_we    = '0;
    req_wdata = wdata_i;
    unique case (ctrl_i[1:0])
      LSU_W_BYTE: begin
        req_wdata = {NB{wdata_i[7:0]}};
        req_we    = NB'(1) << addr_i[1:0];
      end
      LSU_W_HALF: begin
        req_wdata = {(NB/2){wdata_i[15:0]}};
        req_we    = NB'(3) << {addr_i[1], 1'b0};
      end
      default: req_we = '1;
    endcase
    if (!ctrl_i[3]) req_we = '0;
  end

`ifdef JEDRO_1_LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero in IDLE, so it starts from zero on every entry to WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == LSU_IDLE) cnt_d = '0;
    else if (!dram_ack && !dram_err) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign timeout = (state_q == LSU_WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  // No abort counter in this build: WAIT lasts until the bus answers.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    stb_d      = stb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ctrl_d     = ctrl_q;
    off_d      = off_q;
    rd_d       = rd_q;
    rf_we_d    = 1'b0;
    rf_wdata_d = rf_wdata_q;
    mis_ld_d   = 1'b0;
    mis_st_d   = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      LSU_IDLE: begin
        if (ctrl_valid_i) begin
          if (lsu_misaligned(ctrl_i, addr_i[1:0])) begin
            mis_st_d = ctrl_i[3];
            mis_ld_d = ~ctrl_i[3];
          end else begin
            state_d = LSU_WAIT;
            stb_d   = 1'b1;
            we_d    = req_we;
            addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            wdata_d = req_wdata;
            ctrl_d  = ctrl_i;
            off_d   = addr_i[1:0];
            rd_d    = regdest_i;
          end
        end
      end
      LSU_WAIT: begin
        // An error beats a simultaneous ack.
        if (dram_err || timeout) begin
          state_d = LSU_IDLE;
          stb_d   = 1'b0;
          we_d    = '0;
          err_d   = 1'b1;
        end else if (dram_ack) begin
          state_d = LSU_IDLE;
          stb_d   = 1'b0;
          we_d    = '0;
          if (!ctrl_q[3]) begin
            rf_we_d    = 1'b1;
            rf_wdata_d = ld_data;
          end
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= LSU_IDLE;
      we_q       <= '0;
      stb_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_q     <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_wdata_q <= '0;
      mis_ld_q   <= 1'b0;
      mis_st_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      stb_q      <= stb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ctrl_q     <= ctrl_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      rf_we_q    <= rf_we_d;
      rf_wdata_q <= rf_wdata_d;
      mis_ld_q   <= mis_ld_d;
      mis_st_q   <= mis_st_d;
      err_q      <= err_d;
    end
  end

  assign busy_o             = (state_q == LSU_WAIT);
  assign rf_we_o            = rf_we_q;
  assign rf_wdata_o         = rf_wdata_q;
  assign regdest_o          = rd_q;
  assign misaligned_load_o  = mis_ld_q;
  assign misaligned_store_o = mis_st_q;
  assign bus_err_o          = err_q;
  assign dram_we            = we_q;
  assign dram_stb           = stb_q;
  assign dram_addr          = addr_q;
  assign dram_wdata         = wdata_q;

endmodule
